// File: rtl/draw_scheduler.sv
// Draw-command scheduler: buffers circle/clear commands, launches the circle engine,
// sweeps the framebuffer for clears, watches for engine hangs and counts retired commands.
module draw_scheduler #(
  parameter int DEPTH_LOG2 = 2,
  parameter int FB_WORDS   = 76800,
  parameter int ADDR_W     = 17,
  parameter int TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [9:0]        cmd_cx,
  input  logic [9:0]        cmd_cy,
  input  logic [8:0]        cmd_r,
  input  logic [11:0]       cmd_color,
  output logic              eng_start,
  output logic [9:0]        eng_cx,
  output logic [9:0]        eng_cy,
  output logic [8:0]        eng_r,
  output logic [11:0]       eng_color,
  input  logic              eng_done,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_data,
  output logic              idle,
  output logic              err,
  output logic [15:0]       done_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CMD_W = 42;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  // state  | meaning
  // IDLE   | waiting for a queued command; pops the head when one is present
  // LAUNCH | single-cycle eng_start pulse, watchdog reloaded
  // WAIT   | circle engine busy; leaves on eng_done or watchdog expiry
  // CLEAR  | writing the fill colour to one framebuffer word per cycle
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CLEAR} state_t;

  state_t                state;
  logic [CMD_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [CMD_W-1:0]      head;
  logic                  head_op;
  logic [9:0]            head_cx;
  logic [9:0]            head_cy;
  logic [8:0]            head_r;
  logic [11:0]           head_color;
  logic [WD_W-1:0]       wd_cnt;

  assign full      = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign idle      = (state == S_IDLE) && empty;

  assign head       = mem[rd_ptr];
  assign head_op    = head[41];
  assign head_cx    = head[40:31];
  assign head_cy    = head[30:21];
  assign head_r     = head[20:12];
  assign head_color = head[11:0];

  // Storage needs no reset: an entry is only read once count says it was written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_cx, cmd_cy, cmd_r, cmd_color};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      eng_start <= 1'b0;
      eng_cx    <= '0;
      eng_cy    <= '0;
      eng_r     <= '0;
      eng_color <= '0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      err       <= 1'b0;
      done_cnt  <= '0;
      wd_cnt    <= '0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            if (head_op) begin
              state   <= S_CLEAR;
              fb_we   <= 1'b1;
              fb_addr <= '0;
              fb_data <= head_color;
            end else begin
              state     <= S_LAUNCH;
              eng_start <= 1'b1;
              eng_cx    <= head_cx;
              eng_cy    <= head_cy;
              eng_r     <= head_r;
              eng_color <= head_color;
            end
          end
        end
        S_LAUNCH: begin
          wd_cnt <= WD_W'(TIMEOUT - 1);
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // Down-counter reaches zero on the TIMEOUT-th cycle without eng_done.
          if (eng_done) begin
            done_cnt <= done_cnt + 1'b1;
            state    <= S_IDLE;
          end else if (wd_cnt == '0) begin
            err      <= 1'b1;
            done_cnt <= done_cnt + 1'b1;
            state    <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
        S_CLEAR: begin
          if (fb_addr == ADDR_W'(FB_WORDS - 1)) begin
            fb_we    <= 1'b0;
            done_cnt <= done_cnt + 1'b1;
            state    <= S_IDLE;
          end else begin
            fb_addr <= fb_addr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
